// File: rtl/polyphase_seq_ctrl.sv
// Polyphase decimator sequencing controller.
// Walks the FSM IDLE -> FILL -> RUN -> DRAIN. It produces the delay-line shift
// enable and the downsample strobe, and tracks the polyphase index and frame count.
module polyphase_seq_ctrl #(
  parameter int FW = 8
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          START,
  input  logic          STOP,
  input  logic [2:0]    M_SEL,
  input  logic          IN_VALID,
  output logic          ENABLE,
  output logic          DS_STB,
  output logic [2:0]    PHASE,
  output logic [1:0]    STATE,
  output logic          BUSY,
  output logic          CFG_ERR,
  output logic [FW-1:0] FRAME_CNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam logic [FW-1:0] FRAME_ONE = FW'(1);

  state_e        state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [2:0]    fill_cnt_q, fill_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          cfg_err_q, cfg_err_d;
  logic          busy_q, busy_d;
  logic [3:0]    m_reg_q, m_reg_d;

  logic [3:0]    m_last;
  logic          at_last;
  logic          ds_raw;

  // The last polyphase index is M-1; the downsample strobe fires on a valid sample at that index.
  assign m_last  = m_reg_q - 4'd1;
  assign at_last = ({1'b0, phase_q} == m_last);

  // Next-state logic, and the shift and strobe outputs, which reset forces low.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    phase_d     = phase_q;
    fill_cnt_d  = fill_cnt_q;
    frame_cnt_d = frame_cnt_q;
    cfg_err_d   = cfg_err_q;
    m_reg_d     = m_reg_q;
    ds_raw      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // START together with STOP is ambiguous and is dropped without touching CFG_ERR.
        if (START && !STOP) begin
          if (M_SEL == 3'd0) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d     = S_FILL;
            phase_d     = 3'd0;
            fill_cnt_d  = 3'd0;
            frame_cnt_d = '0;
            cfg_err_d   = 1'b0;
            m_reg_d     = {1'b0, M_SEL} + 4'd1;
          end
        end
      end
      S_FILL: begin
        if (STOP) begin
          state_d = S_IDLE;
        end else if (IN_VALID) begin
          fill_cnt_d = fill_cnt_q + 3'd1;
          if ({1'b0, fill_cnt_d} == m_last) begin
            state_d = S_RUN;
            phase_d = 3'd0;
          end
        end
      end
      default: begin // S_RUN, S_DRAIN
        ds_raw = IN_VALID && at_last;
        if (IN_VALID) phase_d = at_last ? 3'd0 : phase_q + 3'd1;
        if (ds_raw) frame_cnt_d = frame_cnt_q + FRAME_ONE;
        if (state_q == S_RUN) begin
          // A stop exactly on a frame boundary returns straight to IDLE; otherwise the frame drains first.
          if (STOP) state_d = ((phase_q == 3'd0 && !IN_VALID) || ds_raw) ? S_IDLE : S_DRAIN;
        end else if (ds_raw) begin
          state_d = S_IDLE;
        end
      end
    endcase

    if (state_d == S_IDLE) phase_d = 3'd0;
    busy_d = (state_d != S_IDLE);

    ENABLE = !RES && (state_q != S_IDLE) && IN_VALID;
    DS_STB = !RES && ds_raw;
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples the pre-edge values.
    if (RES) begin
      state_q     <= S_IDLE;
      phase_q     <= 3'd0;
      fill_cnt_q  <= 3'd0;
      frame_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      m_reg_q     <= 4'd2;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      fill_cnt_q  <= fill_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
      m_reg_q     <= m_reg_d;
    end
  end

  assign PHASE     = phase_q;
  assign STATE     = state_q;
  assign BUSY      = busy_q;
  assign CFG_ERR   = cfg_err_q;
  assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_polyphase_seq_ctrl.sv
// Bench for polyphase_seq_ctrl.
// A cycle model pushes the expected registered outputs to a scoreboard queue.
// Each entry is popped and compared once the DUT updates. Directed spot checks
// against hand-derived constants follow the key scenarios.
module tb_polyphase_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic [2:0] M_SEL = 3'd0;
  logic       IN_VALID = 1'b0;
  logic       ENABLE, DS_STB, BUSY, CFG_ERR;
  logic [2:0] PHASE;
  logic [1:0] STATE;
  logic [7:0] FRAME_CNT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] state;
    logic [2:0] phase;
    logic [7:0] frame;
    logic       cfg;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [1:0] m_state = 2'd0;
  logic [2:0] m_phase = 3'd0;
  logic [2:0] m_fill  = 3'd0;
  logic [7:0] m_frame = 8'd0;
  logic       m_cfg   = 1'b0;
  logic [3:0] m_m     = 4'd2;

  polyphase_seq_ctrl #(.FW(8)) dut (
    .CLK(CLK), .RES(RES), .START(START), .STOP(STOP), .M_SEL(M_SEL),
    .IN_VALID(IN_VALID), .ENABLE(ENABLE), .DS_STB(DS_STB), .PHASE(PHASE),
    .STATE(STATE), .BUSY(BUSY), .CFG_ERR(CFG_ERR), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: the combinational outputs are checked against the
  // model before the edge, and the registered outputs through the scoreboard after it.
  task automatic step(input logic res, input logic st, input logic sp,
                      input logic [2:0] ms, input logic v, input string tag);
    exp_t       e;
    logic       at_last, exp_en, exp_ds;
    logic [2:0] old_phase;
    @(negedge CLK);
    RES = res; START = st; STOP = sp; M_SEL = ms; IN_VALID = v;
    #1;
    at_last = ({1'b0, m_phase} == m_m - 4'd1);
    exp_en  = !res && (m_state != 2'd0) && v;
    exp_ds  = !res && m_state[1] && v && at_last;
    check({tag, "_enable"}, 32'(ENABLE), 32'(exp_en));
    check({tag, "_ds_stb"}, 32'(DS_STB), 32'(exp_ds));

    old_phase = m_phase;
    if (res) begin
      m_state = 2'd0; m_phase = 3'd0; m_fill = 3'd0; m_frame = 8'd0; m_cfg = 1'b0; m_m = 4'd2;
    end else begin
      case (m_state)
        2'd0: if (st && !sp) begin
          if (ms == 3'd0) m_cfg = 1'b1;
          else begin
            m_state = 2'd1; m_phase = 3'd0; m_fill = 3'd0; m_frame = 8'd0; m_cfg = 1'b0;
            m_m = {1'b0, ms} + 4'd1;
          end
        end
        2'd1: if (sp) m_state = 2'd0;
              else if (v) begin
                m_fill++;
                if ({1'b0, m_fill} == m_m - 4'd1) begin m_state = 2'd2; m_phase = 3'd0; end
              end
        default: begin
          if (v) m_phase = at_last ? 3'd0 : m_phase + 3'd1;
          if (exp_ds) m_frame++;
          if (m_state == 2'd2 && sp) m_state = ((old_phase == 3'd0 && !v) || exp_ds) ? 2'd0 : 2'd3;
          else if (m_state == 2'd3 && exp_ds) m_state = 2'd0;
          if (m_state == 2'd0) m_phase = 3'd0;
        end
      endcase
    end
    e.state = m_state; e.phase = m_phase; e.frame = m_frame; e.cfg = m_cfg;
    e.busy = (m_state != 2'd0);
    sb_q.push_back(e);

    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check({tag, "_state"}, 32'(STATE), 32'(e.state));
    check({tag, "_phase"}, 32'(PHASE), 32'(e.phase));
    check({tag, "_frame"}, 32'(FRAME_CNT), 32'(e.frame));
    check({tag, "_cfg_err"}, 32'(CFG_ERR), 32'(e.cfg));
    check({tag, "_busy"}, 32'(BUSY), 32'(e.busy));
  endtask

  initial begin
    // Reset with IN_VALID high: shift and strobe must stay low.
    step(1, 0, 0, 3'd0, 1, "rst0");
    step(1, 0, 0, 3'd0, 1, "rst1");
    check("rst_state", 32'(STATE), 32'd0);
    check("rst_frame", 32'(FRAME_CNT), 32'd0);
    step(0, 0, 1, 3'd0, 1, "idle_stop");

    // M=2 with continuous valid: one FILL sample, then a strobe on every 2nd sample.
    step(0, 1, 0, 3'd1, 1, "m2_start");
    check("m2_fill_state", 32'(STATE), 32'd1);
    step(0, 0, 0, 3'd1, 1, "m2_fill");
    check("m2_run_state", 32'(STATE), 32'd2);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 3'd1, 1, "m2_run");
    check("m2_frame4", 32'(FRAME_CNT), 32'd4);
    step(0, 1, 1, 3'd1, 0, "m2_stop");
    check("m2_stop_idle", 32'(STATE), 32'd0);
    check("m2_frame_hold", 32'(FRAME_CNT), 32'd4);

    // M=4 with toggling valid: PHASE advances only on valid cycles.
    step(0, 1, 0, 3'd3, 0, "m4_start");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 3'd3, 1, "m4_fill");
    check("m4_run_state", 32'(STATE), 32'd2);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 3'd3, (i % 2 == 0), "m4_toggle");
    check("m4_toggle_phase", 32'(PHASE), 32'd1);
    check("m4_toggle_frame", 32'(FRAME_CNT), 32'd1);

    // STOP at PHASE=1 drains: three more valid samples complete the frame.
    step(0, 0, 1, 3'd3, 0, "drain_stop");
    check("drain_state", 32'(STATE), 32'd3);
    step(0, 1, 0, 3'd3, 1, "drain_s1");
    step(0, 0, 1, 3'd3, 1, "drain_s2");
    step(0, 0, 0, 3'd3, 1, "drain_s3");
    check("drain_idle", 32'(STATE), 32'd0);
    check("drain_phase0", 32'(PHASE), 32'd0);
    check("drain_frame", 32'(FRAME_CNT), 32'd2);

    // Illegal M_SEL sets CFG_ERR; START+STOP is dropped; a legal START clears CFG_ERR.
    step(0, 1, 0, 3'd0, 0, "cfg_bad");
    check("cfg_bad_err", 32'(CFG_ERR), 32'd1);
    check("cfg_bad_state", 32'(STATE), 32'd0);
    step(0, 1, 1, 3'd2, 0, "cfg_both");
    step(0, 1, 0, 3'd2, 0, "cfg_good");
    check("cfg_good_err", 32'(CFG_ERR), 32'd0);
    check("cfg_good_state", 32'(STATE), 32'd1);
    step(0, 0, 1, 3'd2, 1, "fill_stop");
    check("fill_stop_idle", 32'(STATE), 32'd0);

    // Reset mid-DRAIN with FRAME_CNT=7.
    step(0, 1, 0, 3'd3, 0, "r_start");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 3'd3, 1, "r_fill");
    for (int i = 0; i < 30; i++) step(0, 0, 0, 3'd3, 1, "r_run");
    step(0, 0, 1, 3'd3, 0, "r_stop");
    check("r_drain_state", 32'(STATE), 32'd3);
    check("r_drain_frame", 32'(FRAME_CNT), 32'd7);
    step(1, 0, 0, 3'd3, 1, "r_pulse");
    check("r_all_zero", {25'd0, PHASE, STATE, BUSY, CFG_ERR}, 32'd0);
    check("r_frame_zero", 32'(FRAME_CNT), 32'd0);

    // FRAME_CNT wraps from 255 to 0.
    step(0, 1, 0, 3'd1, 0, "w_start");
    step(0, 0, 0, 3'd1, 1, "w_fill");
    for (int i = 0; i < 510; i++) step(0, 0, 0, 3'd1, 1, "w_run");
    check("w_frame255", 32'(FRAME_CNT), 32'd255);
    step(0, 0, 0, 3'd1, 1, "w_run_a");
    step(0, 0, 0, 3'd1, 1, "w_run_b");
    check("w_frame_wrap", 32'(FRAME_CNT), 32'd0);
    check("w_still_run", 32'(STATE), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
